// File: rtl/mul_acc_stage_pkg.sv
// mul_acc_stage_pkg
//   Shared definitions for the multiplier accumulator stage: FSM state
//   encodings, the product width and a small state-decode helper.
package mul_acc_stage_pkg;

  // Width of the unsigned product delivered by the 8x8 multiplier.
  localparam int P_W = 16;

  // Block FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A beat accepted in IDLE opens a new block, so the running sum,
  // counter and overflow flag restart from that beat.
  function automatic logic is_fresh(input state_t s);
    return (s == ST_IDLE);
  endfunction

endpackage

// File: rtl/mul_acc_stage_add.sv
// add_nbit
//   Ripple-carry adder, N bits wide. Carry-out is not a port; callers that
//   need the carry widen the operands by one bit and read the sum MSB.
// Ports
//   i_a, i_b : N-bit operands
//   i_ci     : carry-in
//   o_s      : N-bit sum
module add_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s
);

  logic w_c;

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin
    w_c = i_ci;
    o_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/mul_acc_stage.sv
// mul_acc_stage
//   Accumulator stage behind the 8x8 array multiplier. Sums a block of
//   16-bit unsigned products (block end marked by i_p_last) and presents the
//   block sum, beat count and a sticky overflow flag on a result handshake.
//   Optional feature macro: MUL_ACC_SAT_EN -- when defined the accumulator
//   clamps to all-ones on carry; otherwise it wraps. ovf is set either way.
// Ports
//   i_clk      : clock, rising edge
//   i_rst      : synchronous reset, active-high
//   i_clr      : synchronous block abort (drops partial sum and result)
//   i_p_valid  : product beat valid
//   o_p_ready  : stage can accept a beat (combinational)
//   i_p        : 16-bit unsigned product
//   i_p_last   : final beat of the block
//   o_r_valid  : block result valid
//   i_r_ready  : consumer accepts result
//   o_r        : block sum, ACC_W bits
//   o_r_cnt    : beats in block (saturating)
//   o_ovf      : accumulator carry seen within the block
module mul_acc_stage
  import mul_acc_stage_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_p_valid,
  output logic             o_p_ready,
  input  logic [P_W-1:0]   i_p,
  input  logic             i_p_last,
  output logic             o_r_valid,
  input  logic             i_r_ready,
  output logic [ACC_W-1:0] o_r,
  output logic [CNT_W-1:0] o_r_cnt,
  output logic             o_ovf
);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_res;
  logic [CNT_W-1:0]   r_res_cnt;
  logic               r_res_ovf;

  logic               w_fire;
  logic               w_fresh;
  logic               w_carry;
  logic [ACC_W:0]     w_op_a;
  logic [ACC_W:0]     w_op_b;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;

  assign w_fire  = i_p_valid && o_p_ready;
  assign w_fresh = is_fresh(r_state);

  // A fresh block adds the first beat to zero rather than to the stale sum.
  assign w_op_a = w_fresh ? {(ACC_W+1){1'b0}} : {1'b0, r_acc};
  assign w_op_b = {{(ACC_W+1-P_W){1'b0}}, i_p};

  add_nbit #(
    .N (ACC_W + 1)
  ) u_add (
    .i_a  (w_op_a),
    .i_b  (w_op_b),
    .i_ci (1'b0),
    .o_s  (w_sum)
  );

  // The extra top bit of the widened adder is the accumulator carry.
  assign w_carry = w_sum[ACC_W];

  // Saturation / wrap selection for the next accumulator value.
  always_comb begin
`ifdef MUL_ACC_SAT_EN
    // Once clamped, any further nonzero beat carries again, so the sum
    // stays at all-ones for the rest of the block.
    if (w_carry) begin
      w_acc_nxt = {ACC_W{1'b1}};
    end else begin
      w_acc_nxt = w_sum[ACC_W-1:0];
    end
`else
    w_acc_nxt = w_sum[ACC_W-1:0];
`endif
  end

  // Saturating beat counter and sticky overflow for the next beat.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_fresh) begin
      w_cnt_nxt = CNT_W'(1'b1);
      w_ovf_nxt = w_carry;
    end else begin
      if (&r_cnt) begin
        w_cnt_nxt = r_cnt;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1'b1);
      end
      w_ovf_nxt = r_ovf | w_carry;
    end
  end

  // Running sum and result registers; the result is captured with the last beat.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc     <= {ACC_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_ovf     <= 1'b0;
      r_res     <= {ACC_W{1'b0}};
      r_res_cnt <= {CNT_W{1'b0}};
      r_res_ovf <= 1'b0;
    end else if (w_fire) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      if (i_p_last) begin
        r_res     <= w_acc_nxt;
        r_res_cnt <= w_cnt_nxt;
        r_res_ovf <= w_ovf_nxt;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; abort wins over any beat in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (i_p_last) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_ACC;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ACC: begin
          if (w_fire && i_p_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ACC;
          end
        end
        ST_DONE: begin
          if (i_r_ready) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; beats are refused while a result is pending or on abort.
  always_comb begin
    o_p_ready = (r_state != ST_DONE) && !i_clr;
    o_r_valid = (r_state == ST_DONE);
  end

  assign o_r     = r_res;
  assign o_r_cnt = r_res_cnt;
  assign o_ovf   = r_res_ovf;

endmodule

// File: tb/tb_mul_acc_stage.sv
// tb_mul_acc_stage
//   Two instances share one stimulus stream: a default-width stage
//   (ACC_W=24, CNT_W=8) and a narrow one (ACC_W=16, CNT_W=2) that exercises
//   overflow and counter saturation. Expected block results come from an
//   integer model and travel through a scoreboard queue.
module tb_mul_acc_stage;

  logic        clk = 1'b0;
  logic        rst, clr, p_valid, p_last, r_ready;
  logic [15:0] p;

  logic        p_ready_a, r_valid_a, ovf_a;
  logic [23:0] r_a;
  logic [7:0]  cnt_a;
  logic        p_ready_b, r_valid_b, ovf_b;
  logic [15:0] r_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] s_a;
    logic [7:0]  c_a;
    logic        o_a;
    logic [15:0] s_b;
    logic [1:0]  c_b;
    logic        o_b;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] blk[$];

  always #5 clk = ~clk;

  mul_acc_stage #(.ACC_W(24), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_p_valid(p_valid), .o_p_ready(p_ready_a),
    .i_p(p), .i_p_last(p_last), .o_r_valid(r_valid_a), .i_r_ready(r_ready),
    .o_r(r_a), .o_r_cnt(cnt_a), .o_ovf(ovf_a)
  );

  mul_acc_stage #(.ACC_W(16), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_p_valid(p_valid), .o_p_ready(p_ready_b),
    .i_p(p), .i_p_last(p_last), .o_r_valid(r_valid_b), .i_r_ready(r_ready),
    .o_r(r_b), .o_r_cnt(cnt_b), .o_ovf(ovf_b)
  );

  // Integer reference: sum the collected block at width w, counter width cw.
  function automatic void model(input int w, input int cw, output logic [31:0] s,
                                output logic [7:0] c, output logic o);
    logic [32:0] lim, acc, t;
    int n;
    lim = 33'd1 << w;
    acc = 33'd0;
    o   = 1'b0;
    foreach (blk[i]) begin
      t = acc + {17'd0, blk[i]};
      if (t >= lim) begin
        o = 1'b1;
`ifdef MUL_ACC_SAT_EN
        acc = lim - 33'd1;
`else
        acc = t - lim;
`endif
      end else begin
        acc = t;
      end
    end
    s = acc[31:0];
    n = blk.size();
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    c = 8'(n);
  endfunction

  task automatic push_exp();
    exp_t e;
    logic [31:0] s;
    logic [7:0]  c;
    logic        o;
    model(24, 8, s, c, o);
    e.s_a = s[23:0]; e.c_a = c; e.o_a = o;
    model(16, 2, s, c, o);
    e.s_b = s[15:0]; e.c_b = c[1:0]; e.o_b = o;
    exp_q.push_back(e);
    blk.delete();
  endtask

  task automatic beat(input logic [15:0] v, input logic last);
    @(negedge clk);
    p_valid = 1'b1; p = v; p_last = last;
    #1;
    checks++;
    if (p_ready_a !== 1'b1 || p_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready p_ready a=%b b=%b required 1", p_ready_a, p_ready_b);
    end
    blk.push_back(v);
    if (last) push_exp();
  endtask

  task automatic get_result(input string nm);
    exp_t e;
    int   n;
    @(negedge clk);
    p_valid = 1'b0; p_last = 1'b0;
    #1;
    n = 0;
    while (!(r_valid_a && r_valid_b) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s_latency waited %0d cycles, required 0", nm, n);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard empty queue at result", nm);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (r_a !== e.s_a || cnt_a !== e.c_a || ovf_a !== e.o_a) begin
      errors++;
      $display("FAIL %s_a r=%h cnt=%0d ovf=%b required r=%h cnt=%0d ovf=%b",
               nm, r_a, cnt_a, ovf_a, e.s_a, e.c_a, e.o_a);
    end
    checks++;
    if (r_b !== e.s_b || cnt_b !== e.c_b || ovf_b !== e.o_b) begin
      errors++;
      $display("FAIL %s_b r=%h cnt=%0d ovf=%b required r=%h cnt=%0d ovf=%b",
               nm, r_b, cnt_b, ovf_b, e.s_b, e.c_b, e.o_b);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    #1;
    checks++;
    if (r_valid_a !== 1'b0 || r_valid_b !== 1'b0 || p_ready_a !== 1'b1 || p_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL %s_release r_valid=%b%b p_ready=%b%b required r_valid=00 p_ready=11",
               nm, r_valid_a, r_valid_b, p_ready_a, p_ready_b);
    end
  endtask

  task automatic test_reset();
    beat(16'h0003, 1'b1);
    get_result("pre_reset");
    beat(16'h0005, 1'b0);
    beat(16'h0007, 1'b0);
    @(negedge clk);
    p_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    blk.delete();
    checks++;
    if (r_valid_a !== 1'b0 || r_a !== 24'h0 || cnt_a !== 8'd0 || ovf_a !== 1'b0 || p_ready_a !== 1'b1 ||
        r_valid_b !== 1'b0 || r_b !== 16'h0 || cnt_b !== 2'd0 || ovf_b !== 1'b0 || p_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset r_valid=%b%b r=%h/%h cnt=%0d/%0d ovf=%b%b p_ready=%b%b required all zero, p_ready=1",
               r_valid_a, r_valid_b, r_a, r_b, cnt_a, cnt_b, ovf_a, ovf_b, p_ready_a, p_ready_b);
    end
    beat(16'h0004, 1'b1);
    get_result("post_reset");
  endtask

  task automatic test_sum();
    beat(16'h0006, 1'b0);
    beat(16'h00FF, 1'b0);
    beat(16'hFE01, 1'b1);
    get_result("sum");
    checks++;
    if (r_a !== 24'h00FF06 || cnt_a !== 8'd3 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL sum_hold r=%h cnt=%0d ovf=%b required r=00ff06 cnt=3 ovf=0", r_a, cnt_a, ovf_a);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    beat(16'h0001, 1'b0);
    beat(16'h0002, 1'b1);
    e = exp_q[0];
    @(negedge clk);
    p = 16'h0055; p_last = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (r_valid_a !== 1'b1 || p_ready_a !== 1'b0 || p_ready_b !== 1'b0 ||
          r_a !== e.s_a || cnt_a !== e.c_a) begin
        errors++;
        $display("FAIL backpressure cycle %0d r_valid=%b p_ready=%b%b r=%h cnt=%0d required 1 00 %h %0d",
                 i, r_valid_a, p_ready_a, p_ready_b, r_a, cnt_a, e.s_a, e.c_a);
      end
    end
    @(negedge clk);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0; p_valid = 1'b0;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if (r_valid_a !== 1'b0 || p_ready_a !== 1'b1 || r_a !== e.s_a || cnt_a !== e.c_a) begin
      errors++;
      $display("FAIL backpressure_release r_valid=%b p_ready=%b r=%h cnt=%0d required 0 1 %h %0d",
               r_valid_a, p_ready_a, r_a, cnt_a, e.s_a, e.c_a);
    end
    beat(16'h0009, 1'b1);
    get_result("after_bp");
  endtask

  task automatic test_overflow();
    logic [15:0] want;
`ifdef MUL_ACC_SAT_EN
    want = 16'hFFFF;
`else
    want = 16'h0001;
`endif
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b1);
    get_result("ovf");
    checks++;
    if (r_b !== want || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_narrow r=%h ovf=%b required r=%h ovf=1", r_b, ovf_b, want);
    end
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b0);
    beat(16'h0001, 1'b1);
    get_result("ovf_hold");
    beat(16'h0020, 1'b1);
    get_result("ovf_fresh");
  endtask

  task automatic test_abort();
    beat(16'h0003, 1'b0);
    beat(16'h0004, 1'b0);
    @(negedge clk);
    clr = 1'b1; p_valid = 1'b1; p = 16'h0100; p_last = 1'b1;
    #1;
    checks++;
    if (p_ready_a !== 1'b0 || p_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready p_ready=%b%b required 00", p_ready_a, p_ready_b);
    end
    @(negedge clk);
    clr = 1'b0; p_valid = 1'b0; p_last = 1'b0;
    #1;
    blk.delete();
    checks++;
    if (r_valid_a !== 1'b0 || r_valid_b !== 1'b0 || r_a !== 24'h0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL abort_state r_valid=%b%b r=%h cnt=%0d required 00 0 0",
               r_valid_a, r_valid_b, r_a, cnt_a);
    end
    beat(16'h0010, 1'b1);
    get_result("abort_next");
    checks++;
    if (r_a !== 24'h000010 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL abort_next_hold r=%h cnt=%0d required 000010 1", r_a, cnt_a);
    end
    beat(16'h0005, 1'b1);
    @(negedge clk);
    p_valid = 1'b0; p_last = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if (r_valid_a !== 1'b0 || r_a !== 24'h0 || r_valid_b !== 1'b0 || r_b !== 16'h0) begin
      errors++;
      $display("FAIL abort_done r_valid=%b%b r=%h/%h required 00 0/0", r_valid_a, r_valid_b, r_a, r_b);
    end
  endtask

  task automatic test_cnt_sat();
    for (int i = 0; i < 5; i++) beat(16'h0001, (i == 4));
    get_result("cnt_sat");
    checks++;
    if (cnt_b !== 2'd3 || r_b !== 16'd5 || cnt_a !== 8'd5) begin
      errors++;
      $display("FAIL cnt_sat_hold cnt_b=%0d r_b=%0d cnt_a=%0d required 3 5 5", cnt_b, r_b, cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    beat(16'h000A, 1'b1);
    get_result("b2b_0");
    beat(16'h0014, 1'b0);
    beat(16'h001E, 1'b1);
    get_result("b2b_1");
  endtask

  task automatic test_random();
    int len;
    for (int b = 0; b < 8; b++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) beat(16'($urandom_range(0, 65535)), (i == len - 1));
      get_result("rand");
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; p_valid = 1'b0; p_last = 1'b0; r_ready = 1'b0; p = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sum();
    test_backpressure();
    test_overflow();
    test_abort();
    test_cnt_sat();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
